// File: rtl/bus_pkg.sv
// Shared types for the N-core snooping bus controller.
//   bus_op_t     : bus operation carried on the request and snoop buses
//   l2_status_t  : status code returned by the shared L2
//   ctrl_state_t : controller FSM state, also exported for debug
//   OPCODE_W     : width of the requester instruction opcode
package bus_pkg;

    localparam int OPCODE_W = 7;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        L2_BUSY   = 2'b00,
        L2_HIT    = 2'b01,
        L2_FILLED = 2'b10,
        L2_ERROR  = 2'b11
    } l2_status_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_SNOOP   = 3'd2,
        ST_L2      = 3'd3,
        ST_RESP    = 3'd4,
        ST_RELEASE = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/snoop_bus_controller_n_rr_arbiter.sv
// Combinational round-robin arbiter (module rr_arbiter).
//   req   : per-requester request bits
//   ptr   : index with highest priority this round (owned by the parent)
//   grant : one-hot winner, the first requester at or after ptr, modulo N
//   valid : at least one request is present
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/snoop_bus_controller_n.sv
// N-core snooping bus controller.
// Handshake: a core raises req_core and holds it until it sees its bit of
// grant_core; the controller keeps no request queue. A granted transaction
// ends with either a one-cycle resp_valid_out pulse for the requester (data
// on bus_data_out, hit flag on cache_hit_out) or, for op NONE / flush_in /
// reset, with no pulse at all. grant_core is 0 again in the RELEASE cycle.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_core, flush_in         : per-core request / abort of own transaction
//   bus_*_in, opcode_in        : per-core request payload
//   cache_hit_in               : per-core snoop hit
//   grant_core                 : one-hot grant
//   bus_address_out/operation  : snoop broadcast to non-granted cores
//   bus_data_out, cache_hit_out, resp_valid_out : response to requester
//   l2_req, address_to_L2, opcode_out, data_from_L2, cache_hit_L2 : L2 port
//   state_dbg, rr_ptr_dbg      : FSM state and round-robin pointer
module snoop_bus_controller_n
    import bus_pkg::*;
#(
    parameter int N_CORES    = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SNOOP_WAIT = 1,
    parameter int L2_TIMEOUT = 16,
    localparam int PTR_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_CORES-1:0]                req_core,
    input  logic [N_CORES-1:0]                flush_in,
    input  logic [N_CORES-1:0][DATA_W-1:0]    bus_data_in,
    input  logic [N_CORES-1:0][ADDR_W-1:0]    bus_address_in,
    input  logic [N_CORES-1:0][1:0]           bus_operation_in,
    input  logic [N_CORES-1:0][OPCODE_W-1:0]  opcode_in,
    input  logic [N_CORES-1:0]                cache_hit_in,
    output logic [N_CORES-1:0]                grant_core,
    output logic [N_CORES-1:0][DATA_W-1:0]    bus_data_out,
    output logic [N_CORES-1:0][ADDR_W-1:0]    bus_address_out,
    output logic [N_CORES-1:0][1:0]           bus_operation_out,
    output logic [N_CORES-1:0]                cache_hit_out,
    output logic [N_CORES-1:0]                resp_valid_out,
    output logic                              l2_req,
    output logic [ADDR_W-1:0]                 address_to_L2,
    output logic [OPCODE_W-1:0]               opcode_out,
    input  logic [DATA_W-1:0]                 data_from_L2,
    input  logic [1:0]                        cache_hit_L2,
    output ctrl_state_t                       state_dbg,
    output logic [PTR_W-1:0]                  rr_ptr_dbg
);

    localparam int TMO_W = $clog2(L2_TIMEOUT + 1);
    localparam int SW_W  = $clog2(SNOOP_WAIT + 1);

    ctrl_state_t          state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     w_reg;
    logic [ADDR_W-1:0]    lat_addr;
    bus_op_t              lat_op;
    logic [OPCODE_W-1:0]  lat_opcode;
    logic [SW_W-1:0]      snoop_cnt;
    logic [TMO_W-1:0]     tmo_cnt;

    logic [N_CORES-1:0]   arb_grant;
    logic                 arb_valid;
    logic [PTR_W-1:0]     win_idx;
    logic [N_CORES-1:0]   snoop_hits;
    logic [PTR_W-1:0]     src_idx;
    logic                 flush_w;
    logic [PTR_W-1:0]     next_ptr;
    l2_status_t           l2_status;
    logic                 l2_has_data;
    logic                 l2_done;

    rr_arbiter #(.N(N_CORES), .PTR_W(PTR_W)) u_arb (
        .req   (req_core),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (arb_grant[i]) win_idx = PTR_W'(i);
        end
    end

    // grant_core is the one-hot of w while a transaction is live, so it
    // doubles as the mask that removes the requester from snoop and flush.
    assign snoop_hits = cache_hit_in & ~grant_core;
    assign flush_w    = |(flush_in & grant_core);

    // Downward scan so the lowest hitting index is the one left standing.
    always_comb begin
        src_idx = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (snoop_hits[i]) src_idx = PTR_W'(i);
        end
    end

    assign next_ptr    = (w_reg == PTR_W'(N_CORES - 1)) ? '0 : w_reg + PTR_W'(1);
    assign l2_status   = l2_status_t'(cache_hit_L2);
    assign l2_has_data = (l2_status == L2_HIT) || (l2_status == L2_FILLED);
    assign l2_done     = l2_has_data || (l2_status == L2_ERROR) ||
                         (tmo_cnt == TMO_W'(L2_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            w_reg             <= '0;
            lat_addr          <= '0;
            lat_op            <= OP_NONE;
            lat_opcode        <= '0;
            snoop_cnt         <= '0;
            tmo_cnt           <= '0;
            grant_core        <= '0;
            bus_data_out      <= '0;
            bus_address_out   <= '0;
            bus_operation_out <= '0;
            cache_hit_out     <= '0;
            resp_valid_out    <= '0;
            l2_req            <= '0;
            address_to_L2     <= '0;
            opcode_out        <= '0;
        end else begin
            // Response outputs live for exactly one cycle (the RESP state).
            resp_valid_out <= '0;
            bus_data_out   <= '0;
            cache_hit_out  <= '0;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_core <= arb_grant;
                        w_reg      <= win_idx;
                        state      <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    lat_addr   <= bus_address_in[w_reg];
                    lat_op     <= bus_op_t'(bus_operation_in[w_reg]);
                    lat_opcode <= opcode_in[w_reg];
                    snoop_cnt  <= '0;
                    if (bus_operation_in[w_reg] == OP_NONE) begin
                        grant_core <= '0;
                        state      <= ST_RELEASE;
                    end else begin
                        for (int i = 0; i < N_CORES; i++) begin
                            if (!grant_core[i]) begin
                                bus_address_out[i]   <= bus_address_in[w_reg];
                                bus_operation_out[i] <= bus_operation_in[w_reg];
                            end else begin
                                bus_address_out[i]   <= '0;
                                bus_operation_out[i] <= OP_NONE;
                            end
                        end
                        state <= ST_SNOOP;
                    end
                end

                ST_SNOOP: begin
                    if (flush_w) begin
                        bus_address_out   <= '0;
                        bus_operation_out <= '0;
                        grant_core        <= '0;
                        state             <= ST_RELEASE;
                    end else if (snoop_cnt == SW_W'(SNOOP_WAIT - 1)) begin
                        bus_address_out   <= '0;
                        bus_operation_out <= '0;
                        if (|snoop_hits) begin
                            // An upgrade only needs ownership, never data.
                            resp_valid_out[w_reg] <= 1'b1;
                            cache_hit_out[w_reg]  <= 1'b1;
                            bus_data_out[w_reg]   <= (lat_op == BUS_UPGR) ? '0
                                                                          : bus_data_in[src_idx];
                            state                 <= ST_RESP;
                        end else begin
                            l2_req        <= 1'b1;
                            address_to_L2 <= lat_addr;
                            opcode_out    <= lat_opcode;
                            tmo_cnt       <= '0;
                            state         <= ST_L2;
                        end
                    end else begin
                        snoop_cnt <= snoop_cnt + SW_W'(1);
                    end
                end

                ST_L2: begin
                    if (flush_w || l2_done) begin
                        l2_req        <= 1'b0;
                        address_to_L2 <= '0;
                        opcode_out    <= '0;
                    end
                    // Flush takes priority over a response arriving the same cycle.
                    if (flush_w) begin
                        grant_core <= '0;
                        state      <= ST_RELEASE;
                    end else if (l2_done) begin
                        resp_valid_out[w_reg] <= 1'b1;
                        cache_hit_out[w_reg]  <= (l2_status == L2_HIT);
                        bus_data_out[w_reg]   <= l2_has_data ? data_from_L2 : '0;
                        state                 <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_RESP: begin
                    grant_core <= '0;
                    state      <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    rr_ptr <= next_ptr;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg  = state;
    assign rr_ptr_dbg = rr_ptr;

endmodule

// File: tb/tb_snoop_bus_controller_n.sv
module tb_snoop_bus_controller_n;
  import bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 2 + 1 + DW;  // {core, hit, data}

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_core, flush_in, cache_hit_in;
  logic [N-1:0][DW-1:0] bus_data_in;
  logic [N-1:0][AW-1:0] bus_address_in;
  logic [N-1:0][1:0] bus_operation_in;
  logic [N-1:0][6:0] opcode_in;
  logic [N-1:0] grant_core, cache_hit_out, resp_valid_out;
  logic [N-1:0][DW-1:0] bus_data_out;
  logic [N-1:0][AW-1:0] bus_address_out;
  logic [N-1:0][1:0] bus_operation_out;
  logic l2_req;
  logic [AW-1:0] address_to_L2;
  logic [6:0] opcode_out;
  logic [DW-1:0] data_from_L2;
  logic [1:0] cache_hit_L2;
  ctrl_state_t state_dbg;
  logic [1:0] rr_ptr_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic l2_seen;

  snoop_bus_controller_n #(
    .N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .SNOOP_WAIT(2), .L2_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .req_core(req_core), .flush_in(flush_in),
    .bus_data_in(bus_data_in), .bus_address_in(bus_address_in),
    .bus_operation_in(bus_operation_in), .opcode_in(opcode_in),
    .cache_hit_in(cache_hit_in), .grant_core(grant_core),
    .bus_data_out(bus_data_out), .bus_address_out(bus_address_out),
    .bus_operation_out(bus_operation_out), .cache_hit_out(cache_hit_out),
    .resp_valid_out(resp_valid_out), .l2_req(l2_req),
    .address_to_L2(address_to_L2), .opcode_out(opcode_out),
    .data_from_L2(data_from_L2), .cache_hit_L2(cache_hit_L2),
    .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // clock / reset helpers
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_core = '0;
    flush_in = '0;
    cache_hit_in = '0;
    cache_hit_L2 = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // driver tasks
  task automatic set_core(input int c, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [6:0] opc);
    bus_operation_in[c] = op;
    bus_address_in[c] = addr;
    bus_data_in[c] = data;
    opcode_in[c] = opc;
  endtask

  task automatic await_grant(input string tag, input logic [N-1:0] want);
    for (int k = 0; k < 20 && grant_core == '0; k++) tick();
    check(tag, grant_core, want);
    req_core = '0;
  endtask

  task automatic wait_l2(input string tag);
    for (int k = 0; k < 20 && !l2_req; k++) tick();
    check(tag, l2_req, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && state_dbg != ST_IDLE; k++) tick();
    check(tag, state_dbg, ST_IDLE);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string p);
    check({p, "_grant"}, grant_core, '0);
    check({p, "_bop"}, bus_operation_out, '0);
    check({p, "_baddr"}, bus_address_out, '0);
    check({p, "_bdata"}, bus_data_out, '0);
    check({p, "_hit"}, cache_hit_out, '0);
    check({p, "_rvalid"}, resp_valid_out, '0);
    check({p, "_l2req"}, l2_req, 1'b0);
    check({p, "_l2addr"}, address_to_L2, '0);
    check({p, "_opc"}, opcode_out, '0);
    check({p, "_state"}, state_dbg, ST_IDLE);
    check({p, "_ptr"}, rr_ptr_dbg, 2'd0);
  endtask

  // scoreboard: every response pulse pops the oldest expectation
  logic [EW-1:0] mon_e;
  logic [N-1:0][DW-1:0] mon_d;
  int mon_c;

  always @(negedge clk) begin
    if (l2_req) l2_seen = 1'b1;
    if (!reset && resp_valid_out != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", resp_valid_out, '0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = int'(mon_e[EW-1:EW-2]);
        mon_d = '0;
        mon_d[mon_c] = mon_e[DW-1:0];
        check("resp_valid", resp_valid_out, 4'b0001 << mon_c);
        check("resp_data", mon_d, mon_d);
        check("resp_data_bus", bus_data_out, mon_d);
        check("resp_hit", cache_hit_out, {3'b000, mon_e[DW]} << mon_c);
      end
    end
  end

  initial begin
    int cnt;
    int order[4];
    order = '{0, 1, 3, 0};
    req_core = '0;
    flush_in = '0;
    cache_hit_in = '0;
    bus_data_in = '0;
    bus_address_in = '0;
    bus_operation_in = '0;
    opcode_in = '0;
    data_from_L2 = '0;
    cache_hit_L2 = 2'b00;
    l2_seen = 1'b0;

    // reset state
    do_reset();
    check_quiet("rst");

    // L2 hit after two busy cycles, requester core 2
    set_core(2, 2'b01, 32'h100, 32'hAAAA0002, 7'h33);
    req_core[2] = 1'b1;
    await_grant("t1_grant", 4'b0100);
    tick();
    check("t1_bcast_op", bus_operation_out, 8'b01_00_01_01);
    check("t1_bcast_addr", bus_address_out, {32'h100, 32'h0, 32'h100, 32'h100});
    exp_q.push_back({2'd2, 1'b1, 32'hDEADBEEF});
    wait_l2("t1_l2req");
    check("t1_l2addr", address_to_L2, 32'h100);
    check("t1_opcode", opcode_out, 7'h33);
    check("t1_bcast_clear", bus_operation_out, '0);
    tick();
    tick();
    cache_hit_L2 = 2'b01;
    data_from_L2 = 32'hDEADBEEF;
    tick();
    cache_hit_L2 = 2'b00;
    wait_drain("t1_drain");
    wait_idle("t1_idle");
    check("t1_ptr", rr_ptr_dbg, 2'd3);

    // snoop priority: lowest hitting non-requester supplies data
    l2_seen = 1'b0;
    cache_hit_in = 4'b1011;
    bus_data_in[1] = 32'h11111111;
    bus_data_in[3] = 32'h33333333;
    set_core(0, 2'b01, 32'h200, 32'h0000AAAA, 7'h03);
    req_core[0] = 1'b1;
    exp_q.push_back({2'd0, 1'b1, 32'h11111111});
    await_grant("t2_grant", 4'b0001);
    wait_drain("t2_drain");
    wait_idle("t2_idle");
    check("t2_no_l2", l2_seen, 1'b0);
    check("t2_ptr", rr_ptr_dbg, 2'd1);
    cache_hit_in = '0;

    // round robin among cores 0, 1, 3
    do_reset();
    cache_hit_in = 4'b0100;
    bus_data_in[2] = 32'h22222222;
    set_core(0, 2'b01, 32'h010, 32'h0, 7'h01);
    set_core(1, 2'b01, 32'h020, 32'h0, 7'h01);
    set_core(3, 2'b01, 32'h030, 32'h0, 7'h01);
    for (int i = 0; i < 4; i++) exp_q.push_back({order[i][1:0], 1'b1, 32'h22222222});
    req_core = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && grant_core == '0; k++) tick();
      check("t3_grant_order", grant_core, 4'b0001 << order[i]);
      if (i == 3) req_core = '0;
      for (int k = 0; k < 20 && grant_core != '0; k++) tick();
    end
    wait_drain("t3_drain");
    wait_idle("t3_idle");
    cache_hit_in = '0;

    // L2 timeout; a flush from a non-granted core is ignored
    flush_in = 4'b0001;
    data_from_L2 = 32'hBAD0BAD0;
    set_core(1, 2'b10, 32'h300, 32'h0, 7'h11);
    req_core[1] = 1'b1;
    exp_q.push_back({2'd1, 1'b0, 32'h0});
    await_grant("t4_grant", 4'b0010);
    wait_l2("t4_l2req");
    cnt = 0;
    for (int k = 0; k < 12 && !resp_valid_out[1]; k++) begin
      tick();
      cnt++;
    end
    check("t4_timeout_cycles", cnt, 8);
    check("t4_l2req_drop", l2_req, 1'b0);
    flush_in = '0;
    wait_drain("t4_drain");
    wait_idle("t4_idle");
    check("t4_ptr", rr_ptr_dbg, 2'd2);

    // reset in SNOOP aborts with no response
    set_core(1, 2'b10, 32'h600, 32'h0, 7'h22);
    req_core[1] = 1'b1;
    await_grant("t6_grant", 4'b0010);
    for (int k = 0; k < 10 && state_dbg != ST_SNOOP; k++) tick();
    check("t6_in_snoop", state_dbg, ST_SNOOP);
    reset = 1'b1;
    tick();
    check_quiet("t6");
    reset = 1'b0;

    // flush in the second L2 cycle
    set_core(3, 2'b01, 32'h400, 32'h0, 7'h44);
    req_core[3] = 1'b1;
    await_grant("t5_grant", 4'b1000);
    wait_l2("t5_l2req");
    tick();
    flush_in[3] = 1'b1;
    tick();
    flush_in = '0;
    check("t5_grant_drop", grant_core, '0);
    check("t5_l2_drop", l2_req, 1'b0);
    check("t5_no_resp", resp_valid_out, '0);
    wait_idle("t5_idle");
    check("t5_ptr_wrap", rr_ptr_dbg, 2'd0);

    // upgrade with a single snoop hit
    l2_seen = 1'b0;
    cache_hit_in = 4'b0001;
    bus_data_in[0] = 32'h12345678;
    set_core(2, 2'b11, 32'h500, 32'h0, 7'h55);
    req_core[2] = 1'b1;
    exp_q.push_back({2'd2, 1'b1, 32'h0});
    await_grant("t7_grant", 4'b0100);
    wait_drain("t7_drain");
    wait_idle("t7_idle");
    check("t7_no_l2", l2_seen, 1'b0);
    cache_hit_in = '0;

    // op NONE releases without a response or broadcast
    set_core(1, 2'b00, 32'h700, 32'h0, 7'h66);
    req_core[1] = 1'b1;
    await_grant("t8_grant", 4'b0010);
    tick();
    check("t8_release", state_dbg, ST_RELEASE);
    check("t8_grant_drop", grant_core, '0);
    check("t8_no_bcast", bus_operation_out, '0);
    wait_idle("t8_idle");
    check("t8_ptr", rr_ptr_dbg, 2'd2);

    repeat (5) tick();
    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
